// File: rtl/conv_pkg.sv
// Shared definitions for the convolution datapath: operand widths, the
// accumulator state type and the round/shift/saturate helper used by requant stages.
package conv_pkg;

    localparam int CONV_PSUM_W = 21;
    localparam int CONV_OUT_W  = 16;
    localparam int CONV_CALC_W = 64;

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        FINISH = 2'd1,
        HOLD   = 2'd2
    } conv_state_e;

    // Round half up, arithmetic shift right, then clamp to a signed out_w range.
    function automatic logic signed [CONV_CALC_W-1:0] sat_round_shift(
        input logic signed [CONV_CALC_W-1:0] value,
        input int                            shift,
        input int                            out_w = CONV_OUT_W
    );
        logic signed [CONV_CALC_W-1:0] t;
        logic signed [CONV_CALC_W-1:0] lim_hi;
        logic signed [CONV_CALC_W-1:0] lim_lo;
        t = value;
        if (shift > 0) begin
            t = t + (64'sd1 <<< (shift - 1));
        end
        t      = t >>> shift;
        lim_hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lim_lo = -(64'sd1 <<< (out_w - 1));
        if (t > lim_hi) begin
            t = lim_hi;
        end else if (t < lim_lo) begin
            t = lim_lo;
        end
        return t;
    endfunction

endpackage

// File: rtl/conv_requant.sv
// Combinational requantizer: bias add, round, shift, saturate.
// Define RELU_FUSE_EN to clamp negative results to zero.
module conv_requant
    import conv_pkg::*;
#(
    parameter int ACC_W      = 28,
    parameter int OUT_W      = CONV_OUT_W,
    parameter int FRAC_SHIFT = 8
) (
    input  logic signed [ACC_W-1:0] acc,
    input  logic signed [OUT_W-1:0] bias,
    output logic signed [OUT_W-1:0] result
);

    logic signed [CONV_CALC_W-1:0] biased;

    // Bias is in output units, so align it to the accumulator's fractional bits first.
    assign biased = CONV_CALC_W'(acc) + (CONV_CALC_W'(bias) <<< FRAC_SHIFT);

    always_comb begin
        result = OUT_W'(sat_round_shift(biased, FRAC_SHIFT, OUT_W));
`ifdef RELU_FUSE_EN
        if (result[OUT_W-1]) begin
            result = '0;
        end
`endif
    end

endmodule

// File: rtl/conv_channel_accumulator.sv
// Accumulates NUM_CH partial sums per output sample, requantizes and hands the
// result downstream over valid/ready. Optional RELU_FUSE_EN fuses a ReLU into requant.
module conv_channel_accumulator
    import conv_pkg::*;
#(
    parameter int IN_W       = CONV_PSUM_W,
    parameter int NUM_CH     = 6,
    parameter int ACC_W      = 28,
    parameter int OUT_W      = CONV_OUT_W,
    parameter int FRAC_SHIFT = 8
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         in_valid,
    output logic                                         in_ready,
    input  logic signed [IN_W-1:0]                       in_data,
    input  logic signed [OUT_W-1:0]                      bias,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic signed [OUT_W-1:0]                      out_data,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] ch_cnt
);

    localparam int                CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CH_W-1:0]   LAST_CH = CH_W'(NUM_CH - 1);

    conv_state_e               state_q, state_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [CH_W-1:0]           ch_cnt_q, ch_cnt_d;
    logic                      out_valid_q, out_valid_d;
    logic signed [OUT_W-1:0]   out_data_q, out_data_d;
    logic signed [ACC_W-1:0]   in_ext;
    logic signed [OUT_W-1:0]   req_result;

    assign in_ext = ACC_W'(in_data);

    conv_requant #(
        .ACC_W      (ACC_W),
        .OUT_W      (OUT_W),
        .FRAC_SHIFT (FRAC_SHIFT)
    ) u_requant (
        .acc    (acc_q),
        .bias   (bias),
        .result (req_result)
    );

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        ch_cnt_d    = ch_cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        case (state_q)
            ACCUM: begin
                if (in_valid) begin
                    // First channel of a sample overwrites, so no clear cycle is needed.
                    acc_d = (ch_cnt_q == '0) ? in_ext : acc_q + in_ext;
                    if (ch_cnt_q == LAST_CH) begin
                        ch_cnt_d = '0;
                        state_d  = FINISH;
                    end else begin
                        ch_cnt_d = ch_cnt_q + CH_W'(1);
                    end
                end
            end
            FINISH: begin
                out_data_d  = req_result;
                out_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ACCUM;
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            ch_cnt_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            ch_cnt_q    <= ch_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign ch_cnt    = ch_cnt_q;

endmodule

// File: tb/tb_conv_channel_accumulator.sv
// Self-checking bench: transaction-level reference model with a per-cycle compare
// process, directed cases from the test plan and a randomized phase.
module tb_conv_channel_accumulator;

    localparam int IN_W       = 21;
    localparam int NUM_CH     = 6;
    localparam int ACC_W      = 28;
    localparam int OUT_W      = 16;
    localparam int FRAC_SHIFT = 8;
    localparam int CH_W       = 3;

    logic                    clk;
    logic                    rst_n;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [IN_W-1:0]  in_data;
    logic signed [OUT_W-1:0] bias;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] out_data;
    logic [CH_W-1:0]         ch_cnt;

    int checks = 0;
    int errors = 0;

    conv_channel_accumulator #(
        .IN_W       (IN_W),
        .NUM_CH     (NUM_CH),
        .ACC_W      (ACC_W),
        .OUT_W      (OUT_W),
        .FRAC_SHIFT (FRAC_SHIFT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .bias      (bias),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .ch_cnt    (ch_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Reference: floor((sum + bias*2^F) / 2^F + 1/2), clamped, optional ReLU.
    function automatic longint floor_div(input longint a, input longint b);
        longint q;
        q = a / b;
        if ((a % b != 0) && ((a < 0) != (b < 0))) q = q - 1;
        return q;
    endfunction

    function automatic longint ref_out(input longint sum, input longint b);
        longint sc, t, q, hi, lo;
        sc = longint'(1) << FRAC_SHIFT;
        t  = sum + b * sc;
        q  = (FRAC_SHIFT > 0) ? floor_div(2 * t + sc, 2 * sc) : t;
        hi = (longint'(1) << (OUT_W - 1)) - 1;
        lo = -(longint'(1) << (OUT_W - 1));
        if (q > hi) q = hi;
        if (q < lo) q = lo;
`ifdef RELU_FUSE_EN
        if (q < 0) q = 0;
`endif
        return q;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Model state, owned by the compare process.
    int     m_cnt = 0;
    longint m_sum = 0;
    int     m_k   = -1;   // cycles since final accept, -1 when accumulating
    longint m_exp = 0;
    longint m_out = 0;
    bit     chk_en = 1'b0;
    bit     pinned = 1'b0;
    int     dir_done = 0;

    // Directed expectations posted by the stimulus process.
    int     dir_req = 0;
    longint dir_exp [0:63];

    always @(negedge clk) begin
        if (!pinned) begin
            pinned = 1'b1;
            chk("pin_basic",    ref_out(6 * 256, 0), 6);
            chk("pin_round_up", ref_out(128, 0), 1);
            chk("pin_round_hz", ref_out(-128, 0), 0);
            chk("pin_round_dn", ref_out(-129, 0), -1);
            chk("pin_sat_hi",   ref_out(6 * 1048575, 16000), 32767);
`ifdef RELU_FUSE_EN
            chk("pin_sat_lo",   ref_out(-6 * 1048576, -16000), 0);
            chk("pin_relu",     ref_out(-6 * 256, 0), 0);
`else
            chk("pin_sat_lo",   ref_out(-6 * 1048576, -16000), -32768);
            chk("pin_relu",     ref_out(-6 * 256, 0), -6);
`endif
        end
        if (m_k >= 0) m_k++;
        if (m_k == 1) m_exp = ref_out(m_sum, longint'(bias));
        if (chk_en) begin
            if (m_k < 0) begin
                chk("in_ready_accum",  longint'(in_ready), 1);
                chk("out_valid_accum", longint'(out_valid), 0);
                chk("ch_cnt_accum",    longint'(ch_cnt), m_cnt);
                chk("out_data_kept",   longint'(out_data), m_out);
            end else if (m_k == 1) begin
                chk("in_ready_finish",  longint'(in_ready), 0);
                chk("out_valid_finish", longint'(out_valid), 0);
                chk("ch_cnt_finish",    longint'(ch_cnt), 0);
                chk("out_data_finish",  longint'(out_data), m_out);
            end else begin
                chk("in_ready_hold",  longint'(in_ready), 0);
                chk("out_valid_hold", longint'(out_valid), 1);
                chk("ch_cnt_hold",    longint'(ch_cnt), 0);
                chk("out_data_hold",  longint'(out_data), m_exp);
                if (m_k == 2 && dir_done < dir_req) begin
                    chk("directed_result", longint'(out_data), dir_exp[dir_done]);
                    dir_done++;
                end
            end
        end
        if (!rst_n) begin
            m_cnt  = 0;
            m_sum  = 0;
            m_k    = -1;
            m_out  = 0;
            chk_en = 1'b1;
        end else if (m_k < 0 && in_valid) begin
            m_sum = (m_cnt == 0) ? longint'(in_data) : m_sum + longint'(in_data);
            m_cnt++;
            if (m_cnt == NUM_CH) begin
                m_cnt = 0;
                m_k   = 0;
            end
        end else if (m_k >= 2 && out_ready) begin
            m_out = m_exp;
            m_k   = -1;
        end
    end

    bit rdy_rand = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
        if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input int v);
        bit ok;
        int n;
        n = 0;
        in_data  = IN_W'(v);
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            ok = in_ready;
            tick();
            n++;
        end while (!ok && n < 500);
        in_valid = 1'b0;
        if (!ok) begin
            $display("FAIL send_timeout: in_ready stayed 0, got 0 expected 1");
            $fatal(1, "send timeout");
        end
    endtask

    task automatic wait_idle();
        bit ok;
        int n;
        n = 0;
        do begin
            @(negedge clk);
            ok = in_ready;
            tick();
            n++;
        end while (!ok && n < 500);
        if (!ok) begin
            $display("FAIL idle_timeout: in_ready stayed 0, got 0 expected 1");
            $fatal(1, "idle timeout");
        end
    endtask

    task automatic run_sample(input int vals[NUM_CH], input int b, input int maxgap);
        wait_idle();
        bias = OUT_W'(b);
        for (int i = 0; i < NUM_CH; i++) begin
            repeat ($urandom_range(0, maxgap)) begin
                in_data = IN_W'($urandom);
                tick();
            end
            send(vals[i]);
        end
    endtask

    task automatic expect_dir(input longint e);
        int n;
        dir_exp[dir_req] = e;
        dir_req++;
        n = 0;
        while (dir_done < dir_req && n < 100) begin
            tick();
            n++;
        end
        if (dir_done < dir_req) begin
            $display("FAIL result_timeout: out_valid never rose, got 0 expected 1");
            $fatal(1, "result timeout");
        end
    endtask

    initial begin
        int v[NUM_CH];
        logic signed [IN_W-1:0]  r;
        logic signed [OUT_W-1:0] rb;
        int n;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; bias = '0; out_ready = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;

        v = '{256, 256, 256, 256, 256, 256};
        run_sample(v, 0, 0);
        expect_dir(6);

        v = '{128, 0, 0, 0, 0, 0};
        run_sample(v, 0, 0);
        expect_dir(1);
        v = '{-128, 0, 0, 0, 0, 0};
        run_sample(v, 0, 0);
        expect_dir(0);
        v = '{-129, 0, 0, 0, 0, 0};
        run_sample(v, 0, 0);
`ifdef RELU_FUSE_EN
        expect_dir(0);
`else
        expect_dir(-1);
`endif

        v = '{1048575, 1048575, 1048575, 1048575, 1048575, 1048575};
        run_sample(v, 16000, 0);
        expect_dir(32767);
        v = '{-1048576, -1048576, -1048576, -1048576, -1048576, -1048576};
        run_sample(v, -16000, 0);
`ifdef RELU_FUSE_EN
        expect_dir(0);
`else
        expect_dir(-32768);
`endif

        // Backpressure: result held while input is offered and ignored.
        out_ready = 1'b0;
        v = '{256, 256, 256, 256, 256, 256};
        run_sample(v, 0, 0);
        expect_dir(6);
        repeat (5) begin
            in_valid = 1'b1;
            in_data  = IN_W'($urandom);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        run_sample(v, 0, 0);
        expect_dir(6);

        // Reset in the middle of a sample discards the partial sum.
        wait_idle();
        bias = '0;
        for (int i = 0; i < 3; i++) send(256);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        run_sample(v, 0, 0);
        expect_dir(6);
        run_sample(v, 0, 3);
        expect_dir(6);

        v = '{-256, -256, -256, -256, -256, -256};
        run_sample(v, 0, 2);
`ifdef RELU_FUSE_EN
        expect_dir(0);
`else
        expect_dir(-6);
`endif

        // Randomized phase with random backpressure and input gaps.
        rdy_rand = 1'b1;
        for (int s = 0; s < 150; s++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r = IN_W'($urandom);
                if ($urandom_range(0, 9) == 0) r = (r[0]) ? 21'sh0FFFFF : -21'sh100000;
                v[i] = int'(r);
            end
            rb = OUT_W'($urandom);
            run_sample(v, int'(rb), $urandom_range(0, 3));
        end
        rdy_rand  = 1'b0;
        out_ready = 1'b1;
        wait_idle();
        n = 0;
        repeat (3) begin
            tick();
            n++;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
